pmu_counter_req_master: RTL and testbench

// - NoC-clock-side requester for the PMU counter register file: converts one-cycle read/write requests from the AXI-lite slave logic into a four-phase level handshake.
// - The handshake is (counter_*_enable out, counter_*_valid in); the valid inputs are asynchronous, from the counter_clk domain.
// - Synchronizes the returning valid, captures read data, enforces a return-to-zero phase and reports timeouts; one transaction in flight.

---
 rtl/pmu_pkg.sv | 16 +
 rtl/pmu_bit_sync.sv | 23 ++
 rtl/pmu_counter_req_master.sv | 170 +++++++++++++++++
 tb/tb_pmu_counter_req_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// Shared types and address-field widths for the PMU counter requester.
package pmu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2,
      RESP = 2'd3
   } pmu_req_state_e;

   localparam int unsigned PMU_TILE_W  = 7;
   localparam int unsigned PMU_REG_W   = 6;
   localparam int unsigned PMU_ALIGN_W = 3;
   localparam int unsigned PMU_ADDR_W  = PMU_TILE_W + PMU_REG_W + PMU_ALIGN_W;

endpackage

// File: rtl/pmu_bit_sync.sv
// Multi-flop single-bit synchronizer for level signals from the counter clock domain.
module pmu_bit_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_async};
      end
   end

   assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/pmu_counter_req_master.sv
// NoC-side requester: turns single-cycle register requests into a four-phase
// enable/valid handshake with the counter clock domain, with per-phase timeouts.
module pmu_counter_req_master
   import pmu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned ADDR_WIDTH     = PMU_ADDR_W,
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  noc_clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_write_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_error_o,
   output logic                  counter_read_enable_o,
   output logic                  counter_write_enable_o,
   output logic [ADDR_WIDTH-1:0] counter_address_o,
   output logic [DATA_WIDTH-1:0] counter_write_data_o,
   input  logic                  counter_read_valid_i,
   input  logic                  counter_write_valid_i,
   input  logic [DATA_WIDTH-1:0] counter_read_data_i
);

   localparam int unsigned   TW   = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

   pmu_req_state_e        r_state, w_next_state;
   logic                  r_write;
   logic                  r_rd_en, r_wr_en;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_error;
   logic [TW-1:0]         r_timer;
   logic                  r_ready_en;

   logic w_rv_s, w_wv_s, w_sel_v;
   logic w_accept, w_ack_hit, w_req_to, w_ack_to;

   pmu_bit_sync #(.STAGES(SYNC_STAGES)) u_rv_sync (
      .clk     (noc_clk),
      .rst     (rst),
      .i_async (counter_read_valid_i),
      .o_sync  (w_rv_s)
   );

   pmu_bit_sync #(.STAGES(SYNC_STAGES)) u_wv_sync (
      .clk     (noc_clk),
      .rst     (rst),
      .i_async (counter_write_valid_i),
      .o_sync  (w_wv_s)
   );

   assign w_sel_v = r_write ? w_wv_s : w_rv_s;

   // Accept is held off while either synced ack is still high so a stale ack drains first.
   assign req_ready_o = r_ready_en && (r_state == IDLE) && !w_rv_s && !w_wv_s;

   always_ff @(posedge noc_clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_ack_hit    = 1'b0;
      w_req_to     = 1'b0;
      w_ack_to     = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid_i && req_ready_o) begin
               w_accept     = 1'b1;
               w_next_state = REQ;
            end
         end
         REQ: begin
            if (w_sel_v) begin
               w_ack_hit    = 1'b1;
               w_next_state = ACK;
            end else if (r_timer == TMAX) begin
               w_req_to     = 1'b1;
               w_next_state = ACK;
            end
         end
         ACK: begin
            if (!w_sel_v) begin
               w_next_state = RESP;
            end else if (r_timer == TMAX) begin
               w_ack_to     = 1'b1;
               w_next_state = RESP;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge noc_clk or posedge rst) begin
      if (rst) begin
         r_ready_en <= 1'b0;
         r_write    <= 1'b0;
         r_rd_en    <= 1'b0;
         r_wr_en    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_error    <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
         if (w_accept) begin
            r_write <= req_write_i;
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_rd_en <= !req_write_i;
            r_wr_en <= req_write_i;
            r_rdata <= '0;
            r_error <= 1'b0;
         end
         if (w_ack_hit || w_req_to) begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
         end
         if (w_ack_hit && !r_write) begin
            r_rdata <= counter_read_data_i;
         end
         if (w_req_to) begin
            r_error <= 1'b1;
            r_rdata <= '1;
         end
         if (w_ack_to) begin
            r_error <= 1'b1;
         end
      end
   end

   // Timer restarts on every state change and saturates at the timeout value.
   always_ff @(posedge noc_clk or posedge rst) begin
      if (rst) begin
         r_timer <= '0;
      end else if (r_state != w_next_state) begin
         r_timer <= '0;
      end else if ((r_state == REQ || r_state == ACK) && r_timer != TMAX) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   assign rsp_valid_o            = (r_state == RESP);
   assign rsp_rdata_o            = r_rdata;
   assign rsp_error_o            = r_error;
   assign counter_read_enable_o  = r_rd_en;
   assign counter_write_enable_o = r_wr_en;
   assign counter_address_o      = r_addr;
   assign counter_write_data_o   = r_wdata;

endmodule

// File: tb/tb_pmu_counter_req_master.sv
// Scoreboard bench for pmu_counter_req_master with a behavioural counter-domain responder.
module tb_pmu_counter_req_master;

   localparam int unsigned DW = 64;
   localparam int unsigned AW = 16;
   localparam int unsigned TO = 16;

   logic          noc_clk = 1'b0;
   logic          rst;
   logic          req_valid_i, req_ready_o, req_write_i;
   logic [AW-1:0] req_addr_i;
   logic [DW-1:0] req_wdata_i;
   logic          rsp_valid_o, rsp_ready_i, rsp_error_o;
   logic [DW-1:0] rsp_rdata_o;
   logic          counter_read_enable_o, counter_write_enable_o;
   logic [AW-1:0] counter_address_o;
   logic [DW-1:0] counter_write_data_o;
   logic          counter_read_valid_i, counter_write_valid_i;
   logic [DW-1:0] counter_read_data_i;

   pmu_counter_req_master #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .noc_clk                (noc_clk),
      .rst                    (rst),
      .req_valid_i            (req_valid_i),
      .req_ready_o            (req_ready_o),
      .req_write_i            (req_write_i),
      .req_addr_i             (req_addr_i),
      .req_wdata_i            (req_wdata_i),
      .rsp_valid_o            (rsp_valid_o),
      .rsp_ready_i            (rsp_ready_i),
      .rsp_rdata_o            (rsp_rdata_o),
      .rsp_error_o            (rsp_error_o),
      .counter_read_enable_o  (counter_read_enable_o),
      .counter_write_enable_o (counter_write_enable_o),
      .counter_address_o      (counter_address_o),
      .counter_write_data_o   (counter_write_data_o),
      .counter_read_valid_i   (counter_read_valid_i),
      .counter_write_valid_i  (counter_write_valid_i),
      .counter_read_data_i    (counter_read_data_i)
   );

   always #5 noc_clk = ~noc_clk;

   typedef struct packed {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t          sb[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            ack_delay = 5;
   bit            no_ack = 1'b0;
   logic [DW-1:0] model_data = 64'h1234;
   logic [AW-1:0] cur_addr = '0;
   logic [DW-1:0] cur_wdata = '0;
   int            rd_rise = 0, wr_rise = 0, rd_high = 0;
   int            rv_low = 0, wv_low = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Counter-domain responder: acks after ack_delay enabled cycles, drops ack once enable is low.
   initial begin
      int en_cnt;
      en_cnt = 0;
      counter_read_valid_i  = 1'b0;
      counter_write_valid_i = 1'b0;
      counter_read_data_i   = 64'hBAD0_BAD0_BAD0_BAD0;
      forever begin
         @(negedge noc_clk);
         if (counter_read_enable_o || counter_write_enable_o) begin
            en_cnt++;
            if (!no_ack && en_cnt >= ack_delay) begin
               if (counter_read_enable_o) begin
                  counter_read_valid_i = 1'b1;
                  counter_read_data_i  = model_data;
               end else begin
                  counter_write_valid_i = 1'b1;
               end
            end
         end else begin
            en_cnt = 0;
            counter_read_valid_i  = 1'b0;
            counter_write_valid_i = 1'b0;
            counter_read_data_i   = 64'hBAD0_BAD0_BAD0_BAD0;
         end
      end
   end

   // Monitor: response scoreboard plus enable-protocol checks.
   initial begin
      logic prev_rd, prev_wr;
      exp_t e;
      prev_rd = 1'b0;
      prev_wr = 1'b0;
      forever begin
         @(negedge noc_clk);
         #1;
         if (counter_read_enable_o || counter_write_enable_o) begin
            chk("enable_overlap", 64'(counter_read_enable_o && counter_write_enable_o), 64'd0);
            chk("addr_hold", 64'(counter_address_o), 64'(cur_addr));
         end
         if (counter_write_enable_o) chk("wdata_hold", counter_write_data_o, cur_wdata);
         if ((counter_read_enable_o && !prev_rd) || (counter_write_enable_o && !prev_wr))
            chk("rise_after_valid_low", 64'(rv_low >= 2 && wv_low >= 2), 64'd1);
         if (counter_read_enable_o && !prev_rd) rd_rise++;
         if (counter_write_enable_o && !prev_wr) wr_rise++;
         if (counter_read_enable_o) rd_high++;
         prev_rd = counter_read_enable_o;
         prev_wr = counter_write_enable_o;
         rv_low  = counter_read_valid_i  ? 0 : rv_low + 1;
         wv_low  = counter_write_valid_i ? 0 : wv_low + 1;
         if (!rst && rsp_valid_o && rsp_ready_i) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 64'(rsp_valid_o), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_rdata", rsp_rdata_o, e.rdata);
               chk("rsp_error", 64'(rsp_error_o), 64'(e.err));
            end
         end
      end
   end

   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] er, input bit ee, input bit expect_rsp);
      int t;
      exp_t e;
      t = 0;
      while (!req_ready_o && t < 300) begin
         @(negedge noc_clk);
         t++;
      end
      chk("req_ready_wait", 64'(req_ready_o), 64'd1);
      cur_addr    = a;
      cur_wdata   = d;
      req_valid_i = 1'b1;
      req_write_i = wr;
      req_addr_i  = a;
      req_wdata_i = d;
      if (expect_rsp) begin
         e.rdata = er;
         e.err   = ee;
         sb.push_back(e);
      end
      @(negedge noc_clk);
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
      req_addr_i  = '0;
      req_wdata_i = '0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((sb.size() != 0 || rsp_valid_o) && t < 300) begin
         @(negedge noc_clk);
         t++;
      end
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int t;
      rst = 1'b1;
      req_valid_i = 1'b0;
      req_write_i = 1'b0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      rsp_ready_i = 1'b1;
      repeat (3) @(negedge noc_clk);
      chk("rst_req_ready", 64'(req_ready_o), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("rst_enables", 64'({counter_read_enable_o, counter_write_enable_o}), 64'd0);
      chk("rst_addr", 64'(counter_address_o), 64'd0);
      chk("rst_rdata", rsp_rdata_o, 64'd0);
      chk("rst_error", 64'(rsp_error_o), 64'd0);
      rst = 1'b0;
      repeat (2) @(negedge noc_clk);
      chk("post_rst_ready", 64'(req_ready_o), 64'd1);

      // Read with ack after 5 cycles
      rd_rise = 0; wr_rise = 0;
      ack_delay = 5; model_data = 64'h1234;
      issue(1'b0, 16'h0208, '0, 64'h1234, 1'b0, 1'b1);
      wait_done();
      chk("read_rd_pulses", 64'(rd_rise), 64'd1);
      chk("read_wr_pulses", 64'(wr_rise), 64'd0);

      // Write
      rd_rise = 0; wr_rise = 0;
      ack_delay = 3;
      issue(1'b1, 16'h0040, 64'hDEAD, 64'h0, 1'b0, 1'b1);
      wait_done();
      chk("write_wr_pulses", 64'(wr_rise), 64'd1);
      chk("write_rd_pulses", 64'(rd_rise), 64'd0);

      // Request-phase timeout
      no_ack = 1'b1; rd_high = 0;
      issue(1'b0, 16'h0100, '0, '1, 1'b1, 1'b1);
      wait_done();
      chk("timeout_en_cycles", 64'(rd_high), 64'(TO));
      no_ack = 1'b0;

      // Response backpressure
      rsp_ready_i = 1'b0;
      ack_delay = 2; model_data = 64'h5555_AAAA;
      issue(1'b0, 16'h0010, '0, 64'h5555_AAAA, 1'b0, 1'b1);
      t = 0;
      while (!rsp_valid_o && t < 100) begin
         @(negedge noc_clk);
         t++;
      end
      chk("hold_rsp_seen", 64'(rsp_valid_o), 64'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge noc_clk);
         chk("hold_valid", 64'(rsp_valid_o), 64'd1);
         chk("hold_rdata", rsp_rdata_o, 64'h5555_AAAA);
         chk("hold_req_ready", 64'(req_ready_o), 64'd0);
      end
      rsp_ready_i = 1'b1;
      wait_done();

      // Reset while the counter domain is acking
      ack_delay = 3; model_data = 64'h77;
      issue(1'b0, 16'h0300, '0, '0, 1'b0, 1'b0);
      t = 0;
      while (!counter_read_valid_i && t < 100) begin
         @(negedge noc_clk);
         t++;
      end
      chk("midrst_ack_seen", 64'(counter_read_valid_i), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("midrst_enables", 64'({counter_read_enable_o, counter_write_enable_o}), 64'd0);
      chk("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      repeat (2) @(negedge noc_clk);
      rst = 1'b0;
      rd_rise = 0;
      model_data = 64'h99;
      issue(1'b0, 16'h0308, '0, 64'h99, 1'b0, 1'b1);
      wait_done();
      chk("midrst_rd_pulses", 64'(rd_rise), 64'd1);

      // Back-to-back read then write
      rd_rise = 0; wr_rise = 0;
      ack_delay = 2; model_data = 64'hABCD;
      issue(1'b0, 16'h0400, '0, 64'hABCD, 1'b0, 1'b1);
      issue(1'b1, 16'h0408, 64'h1111, 64'h0, 1'b0, 1'b1);
      wait_done();
      chk("b2b_rd_pulses", 64'(rd_rise), 64'd1);
      chk("b2b_wr_pulses", 64'(wr_rise), 64'd1);

      repeat (3) @(negedge noc_clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
